// File: rtl/if_id_queue.sv
// Fetch-to-decode buffer: DEPTH-entry {pc, inst} FIFO feeding the IF/ID output register.
// Optional build macro IFQ_BYPASS_EN loads an input word straight into IF/ID when the FIFO is empty.
module if_id_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_inst,
  output logic        in_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        stallreq_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   r_mem_pc   [DEPTH];
  logic [31:0]   r_mem_inst [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_flush_q;

  logic w_full;
  logic w_deq;
  logic w_enq_ok;
  logic w_bypass;
  logic w_enq;
  logic w_unused_stall;

  assign w_unused_stall = &{1'b0, stall[5:3], stall[0]};

  assign w_full     = (r_count == FULL_CNT);
  assign w_deq      = (r_count != '0) && !stall[1] && !flush;
  assign in_ready   = !rst && (!w_full || w_deq);
  assign w_enq_ok   = in_valid && in_ready && !flush && !r_flush_q;
  assign stallreq_o = w_full;

`ifdef IFQ_BYPASS_EN
  assign w_bypass = w_enq_ok && (r_count == '0) && !stall[1];
`else
  assign w_bypass = 1'b0;
`endif

  // A bypassed word goes straight to IF/ID and never occupies a FIFO slot.
  assign w_enq = w_enq_ok && !w_bypass;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem_pc[r_wptr]   <= in_pc;
      r_mem_inst[r_wptr] <= in_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PW'(1);
      if (w_deq) r_rptr <= r_rptr + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // The word fetched in the cycle after a flush is wrong-path and must be dropped.
  always_ff @(posedge clk) begin
    if (rst) r_flush_q <= 1'b0;
    else     r_flush_q <= flush;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end else if (stall[1] && !stall[2]) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end else if (!stall[1]) begin
      if (w_deq) begin
        id_pc    <= r_mem_pc[r_rptr];
        id_inst  <= r_mem_inst[r_rptr];
        id_valid <= 1'b1;
      end else if (w_bypass) begin
        id_pc    <= in_pc;
        id_inst  <= in_inst;
        id_valid <= 1'b1;
      end else begin
        id_pc    <= '0;
        id_inst  <= '0;
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Testbench for if_id_queue: directed scenarios plus randomized traffic checked against a queue-based model.
// Honours IFQ_BYPASS_EN for the expected fetch-to-decode latency.
module tb_if_id_queue;

  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 0 : 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        in_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        stallreq_o;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] q[$];
  logic        m_flush_q = 1'b0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_inst = '0;
  logic        m_valid = 1'b0;
  logic        exp_ready;
  logic        obs_ready;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst), .in_ready(in_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, sample in_ready before the edge, advance the model across the edge.
  task automatic cycle(input logic r, input logic [5:0] st, input logic fl,
                       input logic v, input logic [31:0] pc, input logic [31:0] inst);
    int          n;
    logic        deq, acc, byp;
    logic [63:0] head;
    rst = r; stall = st; flush = fl; in_valid = v; in_pc = pc; in_inst = inst;
    #2;
    obs_ready = in_ready;
    n = q.size();
    deq = (n != 0) && !st[1] && !fl;
    exp_ready = !r && ((n < DEPTH) || deq);
    acc = v && exp_ready && !fl && !m_flush_q;
    byp = BYP && acc && (n == 0) && !st[1];
    @(posedge clk);
    if (r) begin
      q.delete();
      m_flush_q = 1'b0; m_pc = '0; m_inst = '0; m_valid = 1'b0;
    end else begin
      head = '0;
      if (deq) head = q.pop_front();
      if (fl || (st[1] && !st[2])) begin
        m_pc = '0; m_inst = '0; m_valid = 1'b0;
      end else if (!st[1]) begin
        if (deq) begin
          m_pc = head[63:32]; m_inst = head[31:0]; m_valid = 1'b1;
        end else if (byp) begin
          m_pc = pc; m_inst = inst; m_valid = 1'b1;
        end else begin
          m_pc = '0; m_inst = '0; m_valid = 1'b0;
        end
      end
      if (fl) q.delete();
      else if (acc && !byp) q.push_back({pc, inst});
      m_flush_q = fl;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cycle(1'b1, 6'b0, 1'b0, 1'b1, 32'h40 + 32'(4*i), 32'hDEAD0000);
      vectors++;
      if (obs_ready !== 1'b0) begin
        miscompares++; $display("[TB] FAIL reset_in_ready: got %b expected 0", obs_ready);
      end
      vectors++;
      if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0) begin
        miscompares++; $display("[TB] FAIL reset_outputs: got valid=%b pc=%h inst=%h expected 0/0/0", id_valid, id_pc, id_inst);
      end
      vectors++;
      if (stallreq_o !== 1'b0) begin
        miscompares++; $display("[TB] FAIL reset_stallreq: got %b expected 0", stallreq_o);
      end
    end
    cycle(1'b0, 6'b0, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (id_valid !== 1'b0 || stallreq_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_empty: got valid=%b stallreq=%b expected 0/0", id_valid, stallreq_o);
    end
  endtask

  task automatic test_stream();
    logic ev;
    for (int k = 0; k < 6; k++) begin
      if (k < 3) cycle(1'b0, 6'b0, 1'b0, 1'b1, 32'(4*k), 32'h34010001 + 32'(k));
      else       cycle(1'b0, 6'b0, 1'b0, 1'b0, '0, '0);
      if (k < 3) begin
        vectors++;
        if (obs_ready !== 1'b1) begin
          miscompares++; $display("[TB] FAIL stream_ready[%0d]: got %b expected 1", k, obs_ready);
        end
      end
      ev = (k >= LAT) && (k < LAT + 3);
      vectors++;
      if (id_valid !== ev) begin
        miscompares++; $display("[TB] FAIL stream_valid[%0d]: got %b expected %b", k, id_valid, ev);
      end
      if (ev) begin
        vectors++;
        if (id_pc !== 32'(4*(k-LAT)) || id_inst !== 32'h34010001 + 32'(k-LAT)) begin
          miscompares++; $display("[TB] FAIL stream_word[%0d]: got pc=%h inst=%h expected pc=%h inst=%h",
                                  k, id_pc, id_inst, 32'(4*(k-LAT)), 32'h34010001 + 32'(k-LAT));
        end
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 6'b000011, 1'b0, 1'b1, 32'h10 + 32'(4*i), 32'hA0 + 32'(i));
      vectors++;
      if (obs_ready !== 1'b1 || stallreq_o !== (i == 3)) begin
        miscompares++; $display("[TB] FAIL fill_%0d: got ready=%b stallreq=%b expected 1/%b", i, obs_ready, stallreq_o, i == 3);
      end
    end
    cycle(1'b0, 6'b000011, 1'b0, 1'b1, 32'h20, 32'hA4);
    vectors++;
    if (obs_ready !== 1'b0 || stallreq_o !== 1'b1 || id_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL fill_5th: got ready=%b stallreq=%b valid=%b expected 0/1/0", obs_ready, stallreq_o, id_valid);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 6'b0, 1'b0, 1'b0, '0, '0);
      vectors++;
      if (id_valid !== (i < 4) || (i < 4 && (id_pc !== 32'h10 + 32'(4*i) || id_inst !== 32'hA0 + 32'(i)))) begin
        miscompares++; $display("[TB] FAIL fill_drain_%0d: got valid=%b pc=%h inst=%h expected valid=%b pc=%h",
                                i, id_valid, id_pc, id_inst, i < 4, 32'h10 + 32'(4*i));
      end
      vectors++;
      if (stallreq_o !== 1'b0) begin
        miscompares++; $display("[TB] FAIL fill_stallreq_drop_%0d: got %b expected 0", i, stallreq_o);
      end
    end
  endtask

  task automatic test_flush();
    logic ev;
    for (int i = 0; i < 3; i++) cycle(1'b0, 6'b000111, 1'b0, 1'b1, 32'h60 + 32'(4*i), 32'hB0 + 32'(i));
    cycle(1'b0, 6'b000111, 1'b1, 1'b0, '0, '0);
    vectors++;
    if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_inst !== 32'h0 || stallreq_o !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush_outputs: got valid=%b pc=%h inst=%h stallreq=%b expected 0/0/0/0",
                              id_valid, id_pc, id_inst, stallreq_o);
    end
    cycle(1'b0, 6'b0, 1'b0, 1'b1, 32'h100, 32'hC100);
    vectors++;
    if (id_valid !== 1'b0) begin
      miscompares++; $display("[TB] FAIL flush_drop_inflight: got valid=%b pc=%h expected valid 0", id_valid, id_pc);
    end
    for (int k = 0; k < 3; k++) begin
      if (k == 0) cycle(1'b0, 6'b0, 1'b0, 1'b1, 32'h200, 32'hC200);
      else        cycle(1'b0, 6'b0, 1'b0, 1'b0, '0, '0);
      ev = (k == LAT);
      vectors++;
      if (id_valid !== ev || (ev && id_pc !== 32'h200)) begin
        miscompares++; $display("[TB] FAIL flush_next_word[%0d]: got valid=%b pc=%h expected valid=%b pc=00000200", k, id_valid, id_pc, ev);
      end
    end
  endtask

  task automatic test_bubble();
    for (int i = 0; i < 4; i++) cycle(1'b0, 6'b000011, 1'b0, 1'b1, 32'h300 + 32'(4*i), 32'hD0 + 32'(i));
    cycle(1'b0, 6'b0, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h300) begin
      miscompares++; $display("[TB] FAIL bubble_first: got valid=%b pc=%h expected 1/00000300", id_valid, id_pc);
    end
    cycle(1'b0, 6'b000111, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (id_valid !== 1'b1 || id_pc !== 32'h300 || id_inst !== 32'hD0) begin
      miscompares++; $display("[TB] FAIL bubble_hold: got valid=%b pc=%h inst=%h expected 1/00000300/000000d0", id_valid, id_pc, id_inst);
    end
    cycle(1'b0, 6'b000011, 1'b0, 1'b0, '0, '0);
    vectors++;
    if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0) begin
      miscompares++; $display("[TB] FAIL bubble_loaduse: got valid=%b pc=%h inst=%h expected 0/0/0", id_valid, id_pc, id_inst);
    end
    for (int i = 1; i < 4; i++) begin
      cycle(1'b0, 6'b0, 1'b0, 1'b0, '0, '0);
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h300 + 32'(4*i)) begin
        miscompares++; $display("[TB] FAIL bubble_order_%0d: got valid=%b pc=%h expected 1/%h", i, id_valid, id_pc, 32'h300 + 32'(4*i));
      end
    end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 4; i++) cycle(1'b0, 6'b000011, 1'b0, 1'b1, 32'h400 + 32'(4*i), 32'hE0 + 32'(i));
    cycle(1'b0, 6'b0, 1'b0, 1'b1, 32'h410, 32'hE4);
    vectors++;
    if (obs_ready !== 1'b1 || stallreq_o !== 1'b1 || id_valid !== 1'b1 || id_pc !== 32'h400) begin
      miscompares++; $display("[TB] FAIL full_simul: got ready=%b stallreq=%b valid=%b pc=%h expected 1/1/1/00000400",
                              obs_ready, stallreq_o, id_valid, id_pc);
    end
    for (int i = 1; i < 5; i++) begin
      cycle(1'b0, 6'b0, 1'b0, 1'b0, '0, '0);
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h400 + 32'(4*i) || id_inst !== 32'hE0 + 32'(i)) begin
        miscompares++; $display("[TB] FAIL full_simul_drain_%0d: got valid=%b pc=%h inst=%h expected 1/%h/%h",
                                i, id_valid, id_pc, id_inst, 32'h400 + 32'(4*i), 32'hE0 + 32'(i));
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] st;
    logic       r, fl, v;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 63) == 0);
      fl = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 9) < 7);
      st = 6'($urandom);
      if ($urandom_range(0, 1) == 0) st[1] = 1'b0;
      cycle(r, st, fl, v, $urandom & 32'hFFFF_FFFC, $urandom);
      vectors++;
      if (obs_ready !== exp_ready) begin
        miscompares++; $display("[TB] FAIL rand_in_ready[%0d]: got %b expected %b", n, obs_ready, exp_ready);
      end
      vectors++;
      if (id_valid !== m_valid || id_pc !== m_pc || id_inst !== m_inst) begin
        miscompares++; $display("[TB] FAIL rand_output[%0d]: got valid=%b pc=%h inst=%h expected %b/%h/%h",
                                n, id_valid, id_pc, id_inst, m_valid, m_pc, m_inst);
      end
      vectors++;
      if (stallreq_o !== (q.size() == DEPTH)) begin
        miscompares++; $display("[TB] FAIL rand_stallreq[%0d]: got %b expected %b", n, stallreq_o, q.size() == DEPTH);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_fill();
    test_flush();
    test_bubble();
    test_full_simul();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
